if_fetch_unit: RTL

//   Instruction-fetch stage directly downstream of the PC register. Takes the current fetch
//   PC, issues it on the instruction-SRAM request/address/data handshake, and buffers the

---
 rtl/if_fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: SRAM request handshake plus fetch FIFO feeding ID
module if_fetch_unit #(
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INST  = 32'h00000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] IF_pc,
    input  logic        flush,
    input  logic        ID_allow_in,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        wait_stop,
    output logic        ID_valid,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_inst,
    output logic        ID_adel
);
    localparam int PW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

    state_t          state, state_nx;
    logic [PW:0]     count;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [31:0]     pc_mem   [BUF_DEPTH];
    logic [31:0]     inst_mem [BUF_DEPTH];
    logic            adel_mem [BUF_DEPTH];
    logic [31:0]     req_pc;
    logic [PW+1:0]   occ;
    logic            space, aligned, flush_act;
    logic            push, pop, push_adel;
    logic [31:0]     push_pc, push_inst;

    // An outstanding fetch reserves a FIFO slot so its data always has room.
    assign occ       = (PW+2)'(count) + (PW+2)'(state == WAIT);
    assign space     = occ < (PW+2)'(BUF_DEPTH);
    assign aligned   = IF_pc[1:0] == 2'b00;
    assign flush_act = flush && (state != IDLE);
    assign inst_addr = inst_req ? IF_pc : 32'h0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            req_pc <= 32'h0;
        end else begin
            state <= state_nx;
            if (state == REQ && inst_req && inst_addr_ok)
                req_pc <= IF_pc;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = REQ;
            REQ:     if (inst_req && inst_addr_ok) state_nx = WAIT;
            WAIT: begin
                if (inst_data_ok)  state_nx = REQ;
                else if (flush)    state_nx = DISCARD;
            end
            DISCARD: if (inst_data_ok) state_nx = REQ;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        inst_req  = 1'b0;
        wait_stop = 1'b1;
        push      = 1'b0;
        push_pc   = IF_pc;
        push_inst = NOP_INST;
        push_adel = 1'b0;
        case (state)
            REQ: begin
                if (!flush && space) begin
                    if (aligned) begin
                        inst_req = 1'b1;
                        if (inst_addr_ok) wait_stop = 1'b0;
                    end else begin
                        push      = 1'b1;
                        push_adel = 1'b1;
                        wait_stop = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (!flush && inst_data_ok) begin
                    push      = 1'b1;
                    push_pc   = req_pc;
                    push_inst = inst_rdata;
                end
            end
            default: ;
        endcase
        // The PC register must load its redirect target during a flush.
        if (flush_act) wait_stop = 1'b0;
    end

    assign pop = ID_valid && ID_allow_in;

    always_ff @(posedge clk) begin
        if (!resetn || flush_act) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + (PW+1)'(1);
            else if (!push && pop) count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
            adel_mem[wr_ptr] <= push_adel;
        end
    end

    assign ID_valid = count != '0;
    assign ID_pc    = ID_valid ? pc_mem[rd_ptr]   : 32'h0;
    assign ID_inst  = ID_valid ? inst_mem[rd_ptr] : 32'h0;
    assign ID_adel  = ID_valid ? adel_mem[rd_ptr] : 1'b0;
endmodule
